// File: rtl/lru_assoc_cache.sv
// Fully associative tag/value cache, recency-ordered array (entry 0 = MRU),
// with a one-cycle response and a backpressured dirty-victim eviction port.
module lru_assoc_cache #(
    parameter int TAG_WIDTH   = 8,
    parameter int VALUE_WIDTH = 32,
    parameter int NUM_ENTRIES = 8,
    localparam int CW = $clog2(NUM_ENTRIES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_op,
    input  logic [TAG_WIDTH-1:0]   req_tag,
    input  logic [VALUE_WIDTH-1:0] req_value,
    output logic                   resp_valid,
    output logic                   resp_hit,
    output logic [VALUE_WIDTH-1:0] resp_value,
    output logic                   evict_valid,
    input  logic                   evict_ready,
    output logic [TAG_WIDTH-1:0]   evict_tag,
    output logic [VALUE_WIDTH-1:0] evict_value,
    output logic [CW-1:0]          occupancy
);
    localparam int IW = $clog2(NUM_ENTRIES);
    localparam logic [1:0] OP_WRITE = 2'b01, OP_FILL = 2'b10, OP_INV = 2'b11;

    typedef struct packed {
        logic [TAG_WIDTH-1:0]   tag;
        logic [VALUE_WIDTH-1:0] value;
        logic                   vld;
        logic                   dirty;
    } entry_t;

    typedef enum logic {IDLE, EVICT} state_t;

    entry_t                 ent_q [NUM_ENTRIES];
    entry_t                 ent_d [NUM_ENTRIES];
    entry_t                 hit_ent, new_ent, victim;
    logic [NUM_ENTRIES-1:0] hit_vec;
    logic [IW-1:0]          hit_idx;
    logic                   hit, accept, do_promote, do_insert, do_inv, victim_vld;
    logic [CW-1:0]          occ_d;
    state_t                 state_q, state_d;

    assign req_ready   = (state_q == IDLE);
    assign evict_valid = (state_q == EVICT);
    assign accept      = req_valid & req_ready;

    always_comb begin
        hit_vec = '0;
        hit_idx = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            hit_vec[i] = ent_q[i].vld && (ent_q[i].tag == req_tag);
            if (hit_vec[i]) hit_idx = IW'(i);
        end
    end

    assign hit        = |hit_vec;
    assign hit_ent    = ent_q[hit_idx];
    assign do_promote = accept & hit & (req_op != OP_INV);
    assign do_insert  = accept & ~hit & ((req_op == OP_WRITE) | (req_op == OP_FILL));
    assign do_inv     = accept & hit & (req_op == OP_INV);

    // Victim is the removed entry on invalidate, otherwise whatever falls off the LRU end.
    assign victim     = do_inv ? hit_ent : ent_q[NUM_ENTRIES-1];
    assign victim_vld = (do_inv | do_insert) & victim.vld & victim.dirty;

    always_comb begin
        new_ent = hit_ent;
        if (!hit) begin
            new_ent.tag   = req_tag;
            new_ent.value = req_value;
            new_ent.vld   = 1'b1;
            new_ent.dirty = (req_op == OP_WRITE);
        end else if (req_op == OP_WRITE) begin
            new_ent.value = req_value;
            new_ent.dirty = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) ent_d[i] = ent_q[i];
        if (do_promote || do_insert) begin
            ent_d[0] = new_ent;
            for (int i = 1; i < NUM_ENTRIES; i++)
                if (do_insert || i <= int'(hit_idx)) ent_d[i] = ent_q[i-1];
        end else if (do_inv) begin
            for (int i = 0; i < NUM_ENTRIES - 1; i++)
                if (i >= int'(hit_idx)) ent_d[i] = ent_q[i+1];
            ent_d[NUM_ENTRIES-1] = '0;
        end
    end

    always_comb begin
        occ_d = occupancy;
        if (do_insert && !ent_q[NUM_ENTRIES-1].vld) occ_d = occupancy + CW'(1);
        else if (do_inv)                            occ_d = occupancy - CW'(1);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && victim_vld) state_d = EVICT;
            EVICT:   if (evict_ready)          state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) ent_q[i] <= '0;
            state_q     <= IDLE;
            occupancy   <= '0;
            resp_valid  <= 1'b0;
            resp_hit    <= 1'b0;
            resp_value  <= '0;
            evict_tag   <= '0;
            evict_value <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) ent_q[i] <= ent_d[i];
            state_q    <= state_d;
            occupancy  <= occ_d;
            resp_valid <= accept;
            if (accept) begin
                resp_hit   <= hit;
                resp_value <= hit ? hit_ent.value : '0;
            end
            if (accept && victim_vld) begin
                evict_tag   <= victim.tag;
                evict_value <= victim.value;
            end
        end
    end
endmodule

// File: doc/lru_assoc_cache.md
# lru_assoc_cache

Parametrised fully associative tag/value cache with true-LRU ordering, valid and dirty tracking, a one-cycle request/response handshake, and a dirty-eviction port with backpressure. It sits between a pipeline stage (IF or MEM) and the memory interface: the stage issues lookups, writes, fills and invalidates, and the memory side drains dirty victims through the eviction port.

## Interface
- TAG_WIDTH, 8: tag width in bits.
- VALUE_WIDTH, 32: value width in bits.
- NUM_ENTRIES, 8: entry count, at least 2. CW = $clog2(NUM_ENTRIES+1).
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_op  in  2  00 READ, 01 WRITE, 10 FILL, 11 INVALIDATE.
- req_tag  in  TAG_WIDTH  lookup/insert tag.
- req_value  in  VALUE_WIDTH  data for WRITE/FILL.
- resp_valid  out  1  one-cycle pulse, one per accepted request.
- resp_hit  out  1  tag matched a valid entry at acceptance.
- resp_value  out  VALUE_WIDTH  hit entry value before the update; 0 on miss.
- evict_valid  out  1  dirty victim pending.
- evict_ready  in  1  memory side takes victim.
- evict_tag  out  TAG_WIDTH  victim tag.
- evict_value  out  VALUE_WIDTH  victim value.
- occupancy  out  CW  number of valid entries.

## Operation
- Storage is a recency-ordered array. Entry 0 is MRU and entry NUM_ENTRIES-1 is LRU. Each entry holds tag, value, valid and dirty.
- Match: a one-hot compare of req_tag against valid entries only. Duplicate tags never exist because insertion happens only on a miss.
- READ hit: the entry moves to 0 and entries 0..k-1 shift down by one. Value and dirty are unchanged. READ miss: no state change.
- WRITE hit: the entry moves to 0 with value=req_value and dirty=1.
- WRITE miss: {req_tag, req_value, valid=1, dirty=1} is inserted at 0 and all entries shift down. The old LRU entry is dropped.
- FILL hit: behaves exactly as a READ hit; req_value is ignored.
- FILL miss: behaves as a WRITE miss but with dirty=0.
- INVALIDATE hit: the entry is removed. Entries k+1..N-1 shift up by one, and entry N-1 becomes invalid and clean. INVALIDATE miss: no state change.
- Eviction: a WRITE/FILL miss with the LRU entry valid & dirty, or an INVALIDATE hit on a dirty entry, copies that entry into the evict registers and sets evict_valid.
  - A clean or invalid victim is silently dropped.
- FSM has two states:
  - IDLE: req_ready=1.
  - EVICT: evict_valid=1, req_ready=0.
  - IDLE→EVICT on an accepted request that produces a dirty victim.
  - EVICT→IDLE on evict_ready.
- occupancy: +1 on an insert when the LRU entry is invalid; −1 on an INVALIDATE hit; otherwise unchanged. It saturates at NUM_ENTRIES by construction.

## Timing
- Reset values:
  - All entries invalid, clean, tag 0, value 0.
  - resp_valid=0, resp_hit=0, resp_value=0.
  - evict_valid=0, evict_tag=0, evict_value=0.
  - occupancy=0, req_ready=1, FSM in IDLE.
- Array update and victim capture happen on the acceptance edge.
- The response is registered: resp_valid/resp_hit/resp_value are valid in the cycle after acceptance.
- Back-to-back requests are accepted every cycle in IDLE. A request in cycle n+1 sees the array state updated by request n.
- evict_valid rises in the cycle after the causing acceptance. It is held, together with stable evict_tag/evict_value, until the edge where evict_ready=1.
- req_ready falls in that same cycle, so the response pulse of the causing request coincides with the first cycle of evict_valid.
- req_ready returns to 1 in the cycle after the handshake edge. Minimum stall is one cycle with evict_ready tied high.
- evict_ready with evict_valid=0 is ignored. req_valid with req_ready=0 is not accepted and does not change state.
- Reset asserted mid-operation clears all state immediately, including a pending victim. The victim is lost and no response is produced for an in-flight request.
- resp_value and resp_hit hold their last values when resp_valid=0.

## Test plan
- NUM_ENTRIES=4. FILL tags 1,2,3,4 (values 0x10..0x40), then READ 9 → 4 responses with hit=0, occupancy=4, READ 9 resp_hit=0, resp_value=0, no evict_valid.
- READ 1 after the above → hit=1, value=0x10. Then FILL 5 → tag 2 is dropped (LRU), no evict; READ 2 → miss, READ 1 → hit.
- WRITE 7=0xAA on a full cache whose LRU is dirty tag 3=0x33 → next cycle resp_hit=0, evict_valid=1, evict_tag=3, evict_value=0x33, req_ready=0. Hold evict_ready=0 for 3 cycles → outputs stable; pulse evict_ready → req_ready=1 next cycle.
- INVALIDATE a middle tag → occupancy −1 and the order of the remaining entries is preserved. INVALIDATE a dirty tag → evict_valid with that tag/value.
- Back-to-back WRITE 6=0x1 then READ 6 on consecutive cycles → READ resp_hit=1, resp_value=0x1.
- Assert rst with evict_valid=1 and a request in flight → all outputs at reset values, occupancy=0, and a subsequent READ of any prior tag misses.
